// File: rtl/core_if_if.sv
// Avalon-MM bus bundle for the instruction memory port.
// The master issues word reads; the slave returns data in order on read_data_valid.
interface i_avl_bus;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        request_ready;

  modport master (
    output address, byte_en, read, write, write_data,
    input  read_data, read_data_valid, request_ready
  );

  modport slave (
    input  address, byte_en, read, write, write_data,
    output read_data, read_data_valid, request_ready
  );
endinterface

// File: rtl/core_if.sv
// RV32IC instruction fetch: word reads into a 4-entry FIFO, a halfword realigner that
// emits 16/32-bit instructions to decode, and redirect handling with stale-response drop.
module core_if #(
  parameter logic [31:0] REST_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rest,
  i_avl_bus.master    avl_m0,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] jump_addr,
  input  logic        jump_en,
  input  logic        flush_en,
  output logic [31:0] bp_istr,
  output logic [31:0] bp_pc,
  input  logic [31:0] bp_jump_addr,
  input  logic        bp_jump_en,
  output logic [31:0] fd_istr,
  output logic [31:0] fd_pc,
  output logic        fd_valid,
  output logic        fd_jump,
  input  logic        fd_ready,
  input  logic        ctr_stop
);

  localparam int unsigned Depth = 4;

  logic [31:0] fifo_q [Depth];
  logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  logic [2:0]  count_q, count_d, out_q, out_d, stale_q, stale_d;
  logic [29:0] fetch_wa_q, fetch_wa_d;
  logic [31:0] cur_pc_q, cur_pc_d, lp_next_q, lp_next_d;
  logic        half_q, half_d, req_q;
  logic [31:0] fd_istr_q, fd_pc_q;
  logic        fd_valid_q, fd_jump_q;

  logic [31:0] head_w, istr, nxt_pc, target;
  logic [15:0] head_hw, next_lo;
  logic        is32, complete, pop, load;
  logic        ex_redir, bp_redir, redirect;
  logic        issue, accept, rsp, rsp_dec, stale_dec, push;
  logic        unused_mepc;

  // Trap return arrives through jump_*, so the CSR value is not consumed here.
  assign unused_mepc = ^csr_mepc;

  // Realigner view of the FIFO head.
  assign rd_ptr_nxt = rd_ptr_q + 2'd1;
  assign head_w     = fifo_q[rd_ptr_q];
  assign next_lo    = fifo_q[rd_ptr_nxt][15:0];
  assign head_hw    = half_q ? head_w[31:16] : head_w[15:0];
  assign is32       = (head_hw[1:0] == 2'b11);
  assign nxt_pc     = cur_pc_q + (is32 ? 32'd4 : 32'd2);

  always_comb begin
    istr     = {16'h0000, head_hw};
    complete = (count_q != 3'd0);
    pop      = half_q;
    if (is32) begin
      pop = 1'b1;
      if (half_q) begin
        // Straddling instruction needs the following word as well.
        istr     = {next_lo, head_hw};
        complete = (count_q >= 3'd2);
      end else begin
        istr = head_w;
      end
    end
  end

  assign ex_redir = jump_en | flush_en;
  assign load     = complete & (~fd_valid_q | fd_ready) & ~ctr_stop & ~ex_redir;
  assign bp_redir = load & bp_jump_en;
  assign redirect = ex_redir | bp_redir;

  always_comb begin
    if (jump_en) begin
      target = jump_addr;
    end else if (flush_en) begin
      target = lp_next_q;
    end else begin
      target = bp_jump_addr;
    end
  end

  // Read issue: buffered words plus reads in flight never exceed the FIFO depth.
  assign issue     = req_q & ~ctr_stop & (({1'b0, count_q} + {1'b0, out_q}) < 4'd4);
  assign accept    = issue & avl_m0.request_ready;
  assign rsp       = avl_m0.read_data_valid;
  assign rsp_dec   = rsp & (out_q != 3'd0);
  assign stale_dec = rsp & (stale_q != 3'd0);
  assign push      = rsp & (stale_q == 3'd0) & ~redirect;

  assign out_d = out_q + {2'b00, accept} - {2'b00, rsp_dec};

  always_comb begin
    stale_d    = stale_q - {2'b00, stale_dec};
    fetch_wa_d = fetch_wa_q + {29'd0, accept};
    cur_pc_d   = cur_pc_q;
    half_d     = half_q;
    lp_next_d  = lp_next_q;
    count_d    = count_q + {2'b00, push} - {2'b00, load & pop};
    rd_ptr_d   = rd_ptr_q + {1'b0, load & pop};
    wr_ptr_d   = wr_ptr_q + {1'b0, push};
    if (load) begin
      cur_pc_d  = nxt_pc;
      half_d    = is32 ? half_q : ~half_q;
      lp_next_d = nxt_pc;
    end
    if (redirect) begin
      // Everything still in flight belongs to the abandoned path.
      stale_d    = out_d;
      fetch_wa_d = target[31:2];
      cur_pc_d   = target;
      half_d     = target[1];
      lp_next_d  = target;
      count_d    = 3'd0;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      req_q      <= 1'b0;
      out_q      <= 3'd0;
      stale_q    <= 3'd0;
      count_q    <= 3'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      fetch_wa_q <= REST_ADDR[31:2];
      cur_pc_q   <= REST_ADDR;
      half_q     <= REST_ADDR[1];
      lp_next_q  <= REST_ADDR;
    end else begin
      req_q      <= 1'b1;
      out_q      <= out_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_wa_q <= fetch_wa_d;
      cur_pc_q   <= cur_pc_d;
      half_q     <= half_d;
      lp_next_q  <= lp_next_d;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        fifo_q[i] <= 32'h0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= avl_m0.read_data;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      fd_istr_q  <= 32'h0;
      fd_pc_q    <= 32'h0;
      fd_valid_q <= 1'b0;
      fd_jump_q  <= 1'b0;
    end else if (ex_redir) begin
      fd_valid_q <= 1'b0;
      fd_jump_q  <= 1'b0;
    end else if (load) begin
      fd_istr_q  <= istr;
      fd_pc_q    <= cur_pc_q;
      fd_valid_q <= 1'b1;
      fd_jump_q  <= bp_jump_en;
    end else if (fd_ready && !ctr_stop) begin
      fd_valid_q <= 1'b0;
    end
  end

  assign avl_m0.address    = {fetch_wa_q, 2'b00};
  assign avl_m0.byte_en    = 4'hF;
  assign avl_m0.read       = issue;
  assign avl_m0.write      = 1'b0;
  assign avl_m0.write_data = 32'h0;

  assign bp_istr  = istr;
  assign bp_pc    = cur_pc_q;
  assign fd_istr  = fd_istr_q;
  assign fd_pc    = fd_pc_q;
  assign fd_valid = fd_valid_q;
  assign fd_jump  = fd_jump_q;

endmodule

// File: tb/tb_core_if.sv
// Directed bench for core_if: 1-cycle memory holding a generated mix of 16/32-bit code,
// each scenario checks the fd_* instruction stream against a reference decode of that image.
module tb_core_if;
  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [31:0] csr_mepc = 32'h0, jump_addr = 32'h0, bp_jump_addr = 32'h0;
  logic        jump_en = 1'b0, flush_en = 1'b0, bp_jump_en = 1'b0;
  logic        fd_ready = 1'b0, ctr_stop = 1'b0;
  logic [31:0] bp_istr, bp_pc, fd_istr, fd_pc;
  logic        fd_valid, fd_jump;
  logic [31:0] mem [1024];
  logic [31:0] exp_pc, held;
  int          checks = 0;
  int          errors = 0;
  int          got;

  i_avl_bus bus ();

  always #5 clk = ~clk;

  core_if #(.REST_ADDR(32'h0)) dut (
    .clk(clk), .rest(rest), .avl_m0(bus.master), .csr_mepc(csr_mepc),
    .jump_addr(jump_addr), .jump_en(jump_en), .flush_en(flush_en),
    .bp_istr(bp_istr), .bp_pc(bp_pc), .bp_jump_addr(bp_jump_addr), .bp_jump_en(bp_jump_en),
    .fd_istr(fd_istr), .fd_pc(fd_pc), .fd_valid(fd_valid), .fd_jump(fd_jump),
    .fd_ready(fd_ready), .ctr_stop(ctr_stop)
  );

  // Memory: always ready, data one cycle after the accepted read.
  assign bus.request_ready = 1'b1;
  always @(posedge clk) begin
    bus.read_data_valid <= bus.read;
    if (bus.read) bus.read_data <= mem[bus.address[11:2]];
  end

  // Halfword i carries i in its upper bits; every third halfword opens a 32-bit instruction.
  function automatic logic [15:0] ref_hw(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 1;
    ref_hw = {idx[13:0], (idx % 3 == 0) ? 2'b11 : 2'b01};
  endfunction

  function automatic logic [31:0] ref_istr(input logic [31:0] pc);
    logic [15:0] h;
    h = ref_hw(pc);
    ref_istr = (h[1:0] == 2'b11) ? {ref_hw(pc + 32'd2), h} : {16'h0, h};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc);
    logic [15:0] h;
    h = ref_hw(pc);
    ref_next = pc + ((h[1:0] == 2'b11) ? 32'd4 : 32'd2);
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fd_valid !== 1'b0 || fd_jump !== 1'b0 || fd_istr !== 32'h0 || fd_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_fd: valid=%b jump=%b istr=%h pc=%h want 0/0/0/0",
               fd_valid, fd_jump, fd_istr, fd_pc);
    end
    checks++;
    if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: read=%b write=%b wdata=%h want 0/0/0",
               bus.read, bus.write, bus.write_data);
    end
    checks++;
    if (bus.byte_en !== 4'hF) begin
      errors++;
      $display("FAIL reset_byte_en: got %h want f", bus.byte_en);
    end
    fd_ready = 1'b1;
    rest = 1'b0;
  endtask

  task automatic test_sequential();
    exp_pc = 32'h0;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (got != 0) begin
        checks++;
        if (fd_valid !== 1'b1) begin
          errors++;
          $display("FAIL seq_gap: fd_valid=%b want 1 at cycle %0d", fd_valid, c);
        end
      end
      if (fd_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (fd_istr !== 32'h0005_0003) begin
            errors++;
            $display("FAIL seq_first: istr=%h want 00050003", fd_istr);
          end
        end
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc) || fd_jump !== 1'b0 ||
            bus.write !== 1'b0) begin
          errors++;
          $display("FAIL seq_instr: pc=%h istr=%h jump=%b wr=%b want pc=%h istr=%h jump=0 wr=0",
                   fd_pc, fd_istr, fd_jump, bus.write, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 50) begin
      errors++;
      $display("FAIL seq_count: got %0d instructions want >= 50", got);
    end
  endtask

  // Shared shape of the post-redirect scenarios: first instruction constant, then the model.
  task automatic test_exec_jump();
    jump_en = 1'b1;
    flush_en = 1'b1;
    jump_addr = 32'h0000_08b0;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    flush_en = 1'b0;
    exp_pc = 32'h0000_08b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (fd_pc !== 32'h8b0 || fd_istr !== 32'h0000_1161) begin
            errors++;
            $display("FAIL jump_first: pc=%h istr=%h want 000008b0 00001161", fd_pc, fd_istr);
          end
        end
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc) || fd_jump !== 1'b0) begin
          errors++;
          $display("FAIL jump_instr: pc=%h istr=%h jump=%b want pc=%h istr=%h jump=0",
                   fd_pc, fd_istr, fd_jump, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 12) begin
      errors++;
      $display("FAIL jump_count: got %0d instructions want >= 12", got);
    end
  endtask

  task automatic test_bp_jump();
    bp_jump_en = 1'b1;
    bp_jump_addr = 32'h0000_0948;
    @(negedge clk);
    checks++;
    if (fd_valid !== 1'b1 || fd_pc !== exp_pc) begin
      errors++;
      $display("FAIL bp_pre: valid=%b pc=%h want 1 %h", fd_valid, fd_pc, exp_pc);
    end
    held = ref_next(exp_pc);
    checks++;
    if (bp_pc !== held || bp_istr !== ref_istr(held)) begin
      errors++;
      $display("FAIL bp_offer: bp_pc=%h bp_istr=%h want %h %h",
               bp_pc, bp_istr, held, ref_istr(held));
    end
    @(posedge clk);
    #1;
    bp_jump_en = 1'b0;
    @(negedge clk);
    checks++;
    if (fd_valid !== 1'b1 || fd_pc !== held || fd_istr !== ref_istr(held) || fd_jump !== 1'b1) begin
      errors++;
      $display("FAIL bp_taken: valid=%b pc=%h istr=%h jump=%b want 1 %h %h 1",
               fd_valid, fd_pc, fd_istr, fd_jump, held, ref_istr(held));
    end
    @(posedge clk);
    #1;
    exp_pc = 32'h0000_0948;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (fd_pc !== 32'h948 || fd_istr !== 32'h1295_1293) begin
            errors++;
            $display("FAIL bp_first: pc=%h istr=%h want 00000948 12951293", fd_pc, fd_istr);
          end
        end
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc) || fd_jump !== 1'b0) begin
          errors++;
          $display("FAIL bp_instr: pc=%h istr=%h jump=%b want pc=%h istr=%h jump=0",
                   fd_pc, fd_istr, fd_jump, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 12) begin
      errors++;
      $display("FAIL bp_count: got %0d instructions want >= 12", got);
    end
  endtask

  task automatic test_straddle();
    jump_en = 1'b1;
    jump_addr = 32'h0000_03f6;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    exp_pc = 32'h0000_03f6;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (fd_pc !== 32'h3f6 || fd_istr !== 32'h07f1_07ef) begin
            errors++;
            $display("FAIL straddle_first: pc=%h istr=%h want 000003f6 07f107ef", fd_pc, fd_istr);
          end
        end
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc) || fd_jump !== 1'b0) begin
          errors++;
          $display("FAIL straddle_instr: pc=%h istr=%h want pc=%h istr=%h",
                   fd_pc, fd_istr, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 12) begin
      errors++;
      $display("FAIL straddle_count: got %0d instructions want >= 12", got);
    end
  endtask

  task automatic test_stall();
    fd_ready = 1'b0;
    held = exp_pc;
    exp_pc = ref_next(exp_pc);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) ctr_stop = 1'b1;
      @(negedge clk);
      checks++;
      if (fd_valid !== 1'b1 || fd_pc !== held || fd_istr !== ref_istr(held)) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h istr=%h want 1 %h %h at cycle %0d",
                 fd_valid, fd_pc, fd_istr, held, ref_istr(held), c);
      end
      if (c >= 4) begin
        checks++;
        if (bus.read !== 1'b0) begin
          errors++;
          $display("FAIL stall_read: read=%b want 0 at cycle %0d", bus.read, c);
        end
      end
      @(posedge clk);
      #1;
    end
    ctr_stop = 1'b0;
    fd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fd_valid !== 1'b1 || fd_pc !== held) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h want 1 %h", fd_valid, fd_pc, held);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checks++;
      if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc)) begin
        errors++;
        $display("FAIL stall_resume: valid=%b pc=%h istr=%h want 1 %h %h",
                 fd_valid, fd_pc, fd_istr, exp_pc, ref_istr(exp_pc));
      end
      exp_pc = ref_next(exp_pc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    flush_en = 1'b1;
    @(negedge clk);
    checks++;
    if (fd_valid !== 1'b1 || fd_pc !== exp_pc) begin
      errors++;
      $display("FAIL flush_pre: valid=%b pc=%h want 1 %h", fd_valid, fd_pc, exp_pc);
    end
    exp_pc = ref_next(exp_pc);
    @(posedge clk);
    #1;
    flush_en = 1'b0;
    @(negedge clk);
    checks++;
    if (fd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: fd_valid=%b want 0", fd_valid);
    end
    got = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc)) begin
          errors++;
          $display("FAIL flush_instr: pc=%h istr=%h want %h %h",
                   fd_pc, fd_istr, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (got < 8) begin
      errors++;
      $display("FAIL flush_count: got %0d instructions want >= 8", got);
    end
  endtask

  task automatic test_priority();
    jump_en = 1'b1;
    jump_addr = 32'h0000_0100;
    bp_jump_en = 1'b1;
    bp_jump_addr = 32'h0000_0200;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    bp_jump_en = 1'b0;
    exp_pc = 32'h0000_0100;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (fd_pc !== 32'h100 || fd_istr !== 32'h0000_0201 || fd_jump !== 1'b0) begin
            errors++;
            $display("FAIL prio_first: pc=%h istr=%h jump=%b want 00000100 00000201 0",
                     fd_pc, fd_istr, fd_jump);
          end
        end
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc)) begin
          errors++;
          $display("FAIL prio_instr: pc=%h istr=%h want %h %h",
                   fd_pc, fd_istr, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 8) begin
      errors++;
      $display("FAIL prio_count: got %0d instructions want >= 8", got);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rest = 1'b1;
    #1;
    checks++;
    if (fd_valid !== 1'b0 || fd_pc !== 32'h0 || fd_istr !== 32'h0 || bus.read !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: valid=%b pc=%h istr=%h read=%b want 0/0/0/0",
               fd_valid, fd_pc, fd_istr, bus.read);
    end
    repeat (3) @(posedge clk);
    #1;
    rest = 1'b0;
    exp_pc = 32'h0;
    got = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (fd_valid === 1'b1) begin
        checks++;
        if (fd_pc !== exp_pc || fd_istr !== ref_istr(exp_pc)) begin
          errors++;
          $display("FAIL areset_instr: pc=%h istr=%h want %h %h",
                   fd_pc, fd_istr, exp_pc, ref_istr(exp_pc));
        end
        exp_pc = ref_next(exp_pc);
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got < 15) begin
      errors++;
      $display("FAIL areset_count: got %0d instructions want >= 15", got);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {ref_hw(32'(i * 4 + 2)), ref_hw(32'(i * 4))};
    end
    test_reset();
    test_sequential();
    test_exec_jump();
    test_bp_jump();
    test_straddle();
    test_stall();
    test_flush();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
